// File: rtl/alu_ctrl_exec.sv
// RV32I/M integer execute stage: decodes ALUOp/funct fields, runs base ops in one cycle and
// MUL/DIV on a shared radix-2 iterative engine, with valid/ready handshakes on both sides.
module alu_ctrl_exec #(
  parameter int XLEN = 32,
  parameter int EN_M = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic            funct7_b5,
  input  logic            funct7_b0,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [4:0]      operation,
  output logic            illegal
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011;
  localparam logic [4:0] OP_SLL  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SRA  = 5'b00111;
  localparam logic [4:0] OP_SLT  = 5'b01000;
  localparam logic [4:0] OP_SLTU = 5'b01001;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state_reg, state_next;
  logic [SHW-1:0]  cnt_reg;
  logic [XLEN-1:0] acc_reg, quo_reg, opd_reg;
  logic            neg_reg;
  logic [XLEN-1:0] result_reg;
  logic            zero_reg, illegal_reg;
  logic [4:0]      operation_reg;

  logic            accept;
  logic [4:0]      base_op, dec_op;
  logic            dec_ill, dec_m;
  logic [XLEN-1:0] base_res;
  logic [SHW-1:0]  shamt;

  // Base-op selection by funct3 alone; funct7 refinements are applied in the decoder below.
  always_comb begin
    base_op = OP_AND;
    case (funct3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  end

  always_comb begin
    dec_op  = OP_AND;
    dec_ill = 1'b0;
    dec_m   = 1'b0;
    case (alu_op)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        if (funct7_b0) begin
          if (EN_M != 0 && !funct7_b5) begin
            dec_op = {2'b10, funct3};
            dec_m  = 1'b1;
          end else begin
            dec_ill = 1'b1;
          end
        end else if (!funct7_b5) begin
          dec_op = base_op;
        end else if (funct3 == 3'b000) begin
          dec_op = OP_SUB;
        end else if (funct3 == 3'b101) begin
          dec_op = OP_SRA;
        end else begin
          dec_ill = 1'b1;
        end
      end
      // I-type: bit 5 of the immediate only matters for the SRLI/SRAI split
      default: dec_op = (funct7_b5 && funct3 == 3'b101) ? OP_SRA : base_op;
    endcase
  end

  assign shamt = src_b[SHW-1:0];

  always_comb begin
    base_res = src_a & src_b;
    case (dec_op)
      OP_OR:   base_res = src_a | src_b;
      OP_ADD:  base_res = src_a + src_b;
      OP_SUB:  base_res = src_a - src_b;
      OP_XOR:  base_res = src_a ^ src_b;
      OP_SLL:  base_res = src_a << shamt;
      OP_SRL:  base_res = src_a >> shamt;
      OP_SRA:  base_res = $unsigned($signed(src_a) >>> shamt);
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      default: base_res = src_a & src_b;
    endcase
  end

  // Engine load: it always works on magnitudes; the final sign is remembered in neg_reg.
  logic            sgn_a, sgn_b, neg_a, neg_b, neg_load;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    sgn_a    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    sgn_b    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    neg_a    = sgn_a & src_a[XLEN-1];
    neg_b    = sgn_b & src_b[XLEN-1];
    mag_a    = neg_a ? (-src_a) : src_a;
    mag_b    = neg_b ? (-src_b) : src_b;
    neg_load = (funct3[2] && funct3[1]) ? neg_a : (neg_a ^ neg_b);
  end

  // One radix-2 step: shift-add multiply into {acc,quo}, or restoring divide with
  // acc as partial remainder and quo shifting dividend bits out / quotient bits in.
  logic [XLEN:0]   mul_sum, div_sh, div_trial;
  logic [XLEN-1:0] step_acc, step_quo, m_res;

  always_comb begin
    mul_sum   = {1'b0, acc_reg} + {1'b0, opd_reg & {XLEN{quo_reg[0]}}};
    div_sh    = {acc_reg, quo_reg[XLEN-1]};
    div_trial = div_sh - {1'b0, opd_reg};
    if (operation_reg[2]) begin
      if (div_trial[XLEN]) begin
        step_acc = div_sh[XLEN-1:0];
        step_quo = {quo_reg[XLEN-2:0], 1'b0};
      end else begin
        step_acc = div_trial[XLEN-1:0];
        step_quo = {quo_reg[XLEN-2:0], 1'b1};
      end
    end else begin
      step_acc = mul_sum[XLEN:1];
      step_quo = {mul_sum[0], quo_reg[XLEN-1:1]};
    end
  end

  // Sign fix on the final step. High half of a negated 2*XLEN product is ~hi plus the
  // borrow out of the low half. A zero divisor leaves rem = |a|, which re-signs back to a.
  always_comb begin
    case (operation_reg[2:0])
      3'b000:
        m_res = step_quo;
      3'b001, 3'b010, 3'b011:
        m_res = neg_reg ? (~step_acc + {{(XLEN-1){1'b0}}, (step_quo == '0)}) : step_acc;
      3'b100, 3'b101:
        m_res = (opd_reg == '0) ? '1 : (neg_reg ? (-step_quo) : step_quo);
      default:
        m_res = neg_reg ? (-step_acc) : step_acc;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
    accept = in_valid & in_ready & ~flush;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (accept) state_next = dec_m ? BUSY : DONE;
        BUSY: if (cnt_reg == '0) state_next = DONE;
        DONE: begin
          if (accept)         state_next = dec_m ? BUSY : DONE;
          else if (out_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      quo_reg       <= '0;
      opd_reg       <= '0;
      neg_reg       <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b1;
      operation_reg <= OP_AND;
      illegal_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (flush) begin
        cnt_reg <= '0;
      end else if (accept) begin
        operation_reg <= dec_op;
        illegal_reg   <= dec_ill;
        if (dec_m) begin
          cnt_reg <= SHW'(XLEN-1);
          acc_reg <= '0;
          quo_reg <= funct3[2] ? mag_a : mag_b;
          opd_reg <= funct3[2] ? mag_b : mag_a;
          neg_reg <= neg_load;
        end else begin
          result_reg <= base_res;
          zero_reg   <= (base_res == '0);
        end
      end else if (state_reg == BUSY) begin
        acc_reg <= step_acc;
        quo_reg <= step_quo;
        cnt_reg <= cnt_reg - {{(SHW-1){1'b0}}, 1'b1};
        if (cnt_reg == '0) begin
          result_reg <= m_res;
          zero_reg   <= (m_res == '0);
        end
      end
    end
  end

  assign result    = result_reg;
  assign zero      = zero_reg;
  assign operation = operation_reg;
  assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Directed scoreboard bench for alu_ctrl_exec: expected results are queued at issue time
// and compared with immediate assertions when the unit presents its output.
module tb_alu_ctrl_exec;
  localparam int XLEN = 32;
  localparam int MLAT = XLEN + 1;

  localparam logic [4:0] T_AND    = 5'b00000;
  localparam logic [4:0] T_OR     = 5'b00001;
  localparam logic [4:0] T_ADD    = 5'b00010;
  localparam logic [4:0] T_XOR    = 5'b00011;
  localparam logic [4:0] T_SLL    = 5'b00100;
  localparam logic [4:0] T_SRL    = 5'b00101;
  localparam logic [4:0] T_SUB    = 5'b00110;
  localparam logic [4:0] T_SRA    = 5'b00111;
  localparam logic [4:0] T_SLT    = 5'b01000;
  localparam logic [4:0] T_SLTU   = 5'b01001;
  localparam logic [4:0] T_MUL    = 5'b10000;
  localparam logic [4:0] T_MULH   = 5'b10001;
  localparam logic [4:0] T_MULHSU = 5'b10010;
  localparam logic [4:0] T_MULHU  = 5'b10011;
  localparam logic [4:0] T_DIV    = 5'b10100;
  localparam logic [4:0] T_DIVU   = 5'b10101;
  localparam logic [4:0] T_REM    = 5'b10110;
  localparam logic [4:0] T_REMU   = 5'b10111;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      alu_op = 2'b00;
  logic            funct7_b5 = 1'b0;
  logic            funct7_b0 = 1'b0;
  logic [2:0]      funct3 = 3'b000;
  logic [XLEN-1:0] src_a = '0;
  logic [XLEN-1:0] src_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [4:0]      operation;
  logic            illegal;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  op;
    logic        ill;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_ctrl_exec #(.XLEN(XLEN), .EN_M(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct7_b5 (funct7_b5),
    .funct7_b0 (funct7_b0),
    .funct3    (funct3),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .operation (operation),
    .illegal   (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic push(input logic [31:0] res, input logic [4:0] op, input logic ill);
    exp_t e;
    e.res = res;
    e.op  = op;
    e.ill = ill;
    e.z   = (res == 32'd0);
    sb.push_back(e);
  endtask

  task automatic drive(input logic [1:0] op, input logic b5, input logic b0,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    alu_op    = op;
    funct7_b5 = b5;
    funct7_b0 = b0;
    funct3    = f3;
    src_a     = a;
    src_b     = b;
    in_valid  = 1'b1;
  endtask

  // Returns just after the accepting rising edge.
  task automatic send(input logic [1:0] op, input logic b5, input logic b0,
                      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int g;
    g = 0;
    @(negedge clk);
    drive(op, b5, b0, f3, a, b);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("accept_wait", 32'(g < 100), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_op"}, 32'(operation), 32'(e.op));
      chk({tag, "_illegal"}, 32'(illegal), 32'(e.ill));
      chk({tag, "_zero"}, 32'(zero), 32'(e.z));
    end
  endtask

  // Latency counts the cycle after the accepting edge as 1.
  task automatic collect(input string tag, input int want_lat);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    chk({tag, "_latency"}, 32'(lat), 32'(want_lat));
    check_out(tag);
    $display("txn %s: result=%h op=%b illegal=%b zero=%b latency=%0d",
             tag, result, operation, illegal, zero, lat);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic b5, input logic b0,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] wop, input logic wil, input logic [31:0] wres);
    push(wres, wop, wil);
    send(op, b5, b0, f3, a, b);
    collect(tag, wop[4] ? MLAT : 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end of the directed sequence");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_operation", 32'(operation), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Base ops and decode corners
    run("r_sub",     2'b10, 1'b1, 1'b0, 3'b000, 32'd5,        32'd7,        T_SUB,  1'b0, 32'hFFFFFFFE);
    run("srai",      2'b11, 1'b1, 1'b0, 3'b101, 32'h80000000, 32'd4,        T_SRA,  1'b0, 32'hF8000000);
    run("addi_b5",   2'b11, 1'b1, 1'b0, 3'b000, 32'd10,       32'd20,       T_ADD,  1'b0, 32'd30);
    run("ld_add",    2'b00, 1'b1, 1'b1, 3'b111, 32'hFFFFFFFF, 32'd1,        T_ADD,  1'b0, 32'd0);
    run("br_sub",    2'b01, 1'b0, 1'b0, 3'b000, 32'h55,       32'h55,       T_SUB,  1'b0, 32'd0);
    run("r_xor",     2'b10, 1'b0, 1'b0, 3'b100, 32'hF0F0F0F0, 32'h0FF00FF0, T_XOR,  1'b0, 32'hFF00FF00);
    run("r_sll",     2'b10, 1'b0, 1'b0, 3'b001, 32'd3,        32'h21,       T_SLL,  1'b0, 32'd6);
    run("r_srl",     2'b10, 1'b0, 1'b0, 3'b101, 32'h80000000, 32'd4,        T_SRL,  1'b0, 32'h08000000);
    run("r_slt",     2'b10, 1'b0, 1'b0, 3'b010, 32'hFFFFFFFF, 32'd1,        T_SLT,  1'b0, 32'd1);
    run("r_sltu",    2'b10, 1'b0, 1'b0, 3'b011, 32'hFFFFFFFF, 32'd1,        T_SLTU, 1'b0, 32'd0);
    run("r_or",      2'b10, 1'b0, 1'b0, 3'b110, 32'hF0,       32'h0F,       T_OR,   1'b0, 32'hFF);
    run("r_illegal", 2'b10, 1'b1, 1'b0, 3'b001, 32'hF0F0F0F0, 32'hFF00FF00, T_AND,  1'b1, 32'hF000F000);

    // M extension
    run("mulhu",   2'b10, 1'b0, 1'b1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, T_MULHU,  1'b0, 32'hFFFFFFFE);
    run("mul",     2'b10, 1'b0, 1'b1, 3'b000, 32'd7,        32'hFFFFFFFD, T_MUL,    1'b0, 32'hFFFFFFEB);
    run("mulh",    2'b10, 1'b0, 1'b1, 3'b001, 32'h80000000, 32'h80000000, T_MULH,   1'b0, 32'h40000000);
    run("mulhsu",  2'b10, 1'b0, 1'b1, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, T_MULHSU, 1'b0, 32'hFFFFFFFF);
    run("div_ovf", 2'b10, 1'b0, 1'b1, 3'b100, 32'h80000000, 32'hFFFFFFFF, T_DIV,    1'b0, 32'h80000000);
    run("divu_z",  2'b10, 1'b0, 1'b1, 3'b101, 32'h1234,     32'd0,        T_DIVU,   1'b0, 32'hFFFFFFFF);
    run("rem",     2'b10, 1'b0, 1'b1, 3'b110, 32'hFFFFFFF9, 32'd2,        T_REM,    1'b0, 32'hFFFFFFFF);
    run("div_z",   2'b10, 1'b0, 1'b1, 3'b100, 32'hFFFFFFFB, 32'd0,        T_DIV,    1'b0, 32'hFFFFFFFF);
    run("remu_z",  2'b10, 1'b0, 1'b1, 3'b111, 32'h1234,     32'd0,        T_REMU,   1'b0, 32'h1234);
    run("rem_ovf", 2'b10, 1'b0, 1'b1, 3'b110, 32'h80000000, 32'hFFFFFFFF, T_REM,    1'b0, 32'd0);
    run("div",     2'b10, 1'b0, 1'b1, 3'b100, 32'hFFFFFF9C, 32'd7,        T_DIV,    1'b0, 32'hFFFFFFF2);
    run("remu",    2'b10, 1'b0, 1'b1, 3'b111, 32'd100,      32'd7,        T_REMU,   1'b0, 32'd2);

    // Backpressure: result held for 5 cycles, then drained with a same-cycle accept
    out_ready = 1'b0;
    push(32'd7, T_ADD, 1'b0);
    send(2'b00, 1'b0, 1'b0, 3'b000, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", result, 32'd7);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    drive(2'b01, 1'b0, 1'b0, 3'b000, 32'd9, 32'd9);
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    check_out("hold");
    $display("txn hold: result=%h op=%b illegal=%b zero=%b", result, operation, illegal, zero);
    push(32'd0, T_SUB, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    collect("b2b_sub", 1);

    // Flush during a divide
    send(2'b10, 1'b0, 1'b1, 3'b100, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_result", 32'(seen), 32'd0);
    $display("txn flush_div: discarded, out_valid_seen=%b", seen);
    run("post_flush_add", 2'b00, 1'b0, 1'b0, 3'b000, 32'd40, 32'd2, T_ADD, 1'b0, 32'd42);

    // Flush wins over a same-cycle accept
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b0, 3'b000, 32'd1, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_accept_out_valid", 32'(out_valid), 32'd0);
    chk("flush_accept_in_ready", 32'(in_ready), 32'd1);
    $display("txn flush_accept: out_valid=%b in_ready=%b", out_valid, in_ready);

    // Asynchronous reset in the middle of a multiply
    send(2'b10, 1'b0, 1'b1, 3'b000, 32'd12345, 32'd678);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_zero", 32'(zero), 32'd1);
    chk("mid_rst_operation", 32'(operation), 32'd0);
    $display("txn mid_reset: out_valid=%b in_ready=%b result=%h", out_valid, in_ready, result);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("rst_no_result", 32'(seen), 32'd0);
    run("post_rst_add", 2'b00, 1'b0, 1'b0, 3'b000, 32'hFFFFFFFF, 32'd2, T_ADD, 1'b0, 32'd1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
